// File: rtl/weight_pingpong_buffer_if.sv
// Bus bundle for the ping-pong weight buffer: write side from the memory
// controller, bank hand-off pulses, and the per-channel PE-array read ports.
interface weight_pingpong_buffer_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WR_W   = 64,
  parameter int unsigned ADDR_W = 11
);
  localparam int unsigned LANE_W  = $clog2(WR_W / DATA_W);
  localparam int unsigned WADDR_W = ADDR_W - LANE_W;
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // write side
  logic                     wr_vld;
  logic                     wr_rdy;
  logic [CH_W-1:0]          wr_ch;
  logic [WADDR_W-1:0]       wr_waddr;
  logic [WR_W-1:0]          wr_data;

  // bank hand-off
  logic                     wr_commit;
  logic                     rd_release;
  logic                     bank_vld;

  // read side
  logic                     stagger_mode;
  logic [NUM_CH-1:0]        rd_en;
  logic [NUM_CH*ADDR_W-1:0] rd_addr;
  logic [NUM_CH-1:0]        rd_vld;
  logic [NUM_CH*DATA_W-1:0] rd_data;

  modport master (
    output wr_vld, wr_ch, wr_waddr, wr_data, wr_commit, rd_release,
           stagger_mode, rd_en, rd_addr,
    input  wr_rdy, bank_vld, rd_vld, rd_data
  );

  modport slave (
    input  wr_vld, wr_ch, wr_waddr, wr_data, wr_commit, rd_release,
           stagger_mode, rd_en, rd_addr,
    output wr_rdy, bank_vld, rd_vld, rd_data
  );
endinterface

// File: rtl/weight_pingpong_buffer.sv
// Double-banked weight store: the memory controller fills the idle bank with
// wide words while the PE-array columns read the active bank, either
// independently or in systolic (staggered) order driven by channel 0.
module weight_pingpong_buffer #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WR_W   = 64,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                    clk_cal,
  input  logic                    rst_cal,
  weight_pingpong_buffer_if.slave bus
);
  localparam int unsigned LANES   = WR_W / DATA_W;
  localparam int unsigned LANE_W  = $clog2(LANES);
  localparam int unsigned WORDS   = DEPTH / LANES;
  localparam int unsigned WADDR_W = ADDR_W - LANE_W;
  localparam int unsigned NSTG    = (NUM_CH > 1) ? NUM_CH - 1 : 1;

  // storage: [bank][channel][word], each word split into lanes (lane 0 = LSBs)
  logic [LANES-1:0][DATA_W-1:0] r_mem [2][NUM_CH][WORDS];

  // bank FIFO state
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_wr_rdy;
  logic       r_bank_vld;

  logic       w_commit;
  logic       w_release;
  logic       w_wr_acc;
  logic [1:0] w_count_nxt;

  // systolic pipe: stage k holds the channel-0 request for channel k+1
  logic              r_stg_en   [NSTG];
  logic [ADDR_W-1:0] r_stg_addr [NSTG];
  logic              r_stg_bank [NSTG];

  assign bus.wr_rdy   = r_wr_rdy;
  assign bus.bank_vld = r_bank_vld;

  // Bank FIFO events; count saturation makes simultaneous commit/release at the limits collapse to one.
  always_comb begin
    w_commit    = bus.wr_commit && (r_count != 2'd2);
    w_release   = bus.rd_release && (r_count != 2'd0);
    w_count_nxt = r_count + 2'(w_commit) - 2'(w_release);
    w_wr_acc    = !rst_cal && bus.wr_vld && r_wr_rdy && (32'(bus.wr_ch) < NUM_CH);
  end

  // Bank pointers, occupancy and the registered flag decodes.
  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_wr_rdy   <= 1'b1;
      r_bank_vld <= 1'b0;
    end else begin
      if (w_commit)  r_wr_ptr <= ~r_wr_ptr;
      if (w_release) r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_nxt;
      r_wr_rdy   <= (w_count_nxt != 2'd2);
      r_bank_vld <= (w_count_nxt != 2'd0);
    end
  end

  // Word write into the fill bank; contents survive reset.
  always_ff @(posedge clk_cal) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr][bus.wr_ch][bus.wr_waddr] <= bus.wr_data;
    end
  end

  // Shift channel-0 requests down the systolic pipe together with their bank index.
  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      for (int k = 0; k < NSTG; k++) begin
        r_stg_en[k]   <= 1'b0;
        r_stg_addr[k] <= '0;
        r_stg_bank[k] <= 1'b0;
      end
    end else begin
      r_stg_en[0]   <= bus.stagger_mode && bus.rd_en[0] && r_bank_vld;
      r_stg_addr[0] <= bus.rd_addr[ADDR_W-1:0];
      r_stg_bank[0] <= r_rd_ptr;
      for (int k = 1; k < NSTG; k++) begin
        r_stg_en[k]   <= r_stg_en[k-1];
        r_stg_addr[k] <= r_stg_addr[k-1];
        r_stg_bank[k] <= r_stg_bank[k-1];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic              w_req_en;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_req_bank;
    logic [DATA_W-1:0] w_req_data;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_rd_data;

    if (c == 0) begin : g_head
      // Channel 0 issues from its own port in both modes.
      always_comb begin
        w_req_en   = bus.rd_en[0] && r_bank_vld;
        w_req_addr = bus.rd_addr[ADDR_W-1:0];
        w_req_bank = r_rd_ptr;
      end
    end else begin : g_tail
      // Later channels follow the pipe in systolic mode, their own port otherwise.
      always_comb begin
        w_req_en   = bus.rd_en[c] && r_bank_vld;
        w_req_addr = bus.rd_addr[c*ADDR_W +: ADDR_W];
        w_req_bank = r_rd_ptr;
        if (bus.stagger_mode) begin
          w_req_en   = r_stg_en[c-1];
          w_req_addr = r_stg_addr[c-1];
          w_req_bank = r_stg_bank[c-1];
        end
      end
    end

    assign w_req_data = r_mem[w_req_bank][c][w_req_addr[ADDR_W-1:LANE_W]][w_req_addr[LANE_W-1:0]];

    // Registered read result; data holds between accepted reads.
    always_ff @(posedge clk_cal) begin
      if (rst_cal) begin
        r_rd_vld  <= 1'b0;
        r_rd_data <= '0;
      end else begin
        r_rd_vld <= w_req_en;
        if (w_req_en) r_rd_data <= w_req_data;
      end
    end

    assign bus.rd_vld[c]                  = r_rd_vld;
    assign bus.rd_data[c*DATA_W +: DATA_W] = r_rd_data;
  end
endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Scoreboard bench for weight_pingpong_buffer: the stimulus thread updates a
// bank/memory model and queues expected reads; a negedge monitor checks them.
module tb_weight_pingpong_buffer;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int WR_W   = 64;
  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 11;
  localparam int LANES  = WR_W / DATA_W;

  typedef struct {
    int         due;
    logic [7:0] data;
    bit         known;
  } exp_t;

  logic clk_cal = 1'b0;
  logic rst_cal;
  logic rst_q = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // reference model
  logic [7:0] m_mem   [2][NUM_CH][DEPTH];
  bit         m_known [2][NUM_CH][DEPTH];
  int         m_wp, m_rp, m_cnt;
  bit         m_wr_rdy, m_bank_vld;
  exp_t       q [NUM_CH][$];
  logic [7:0] last [NUM_CH];
  bit         last_known [NUM_CH];

  weight_pingpong_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .WR_W(WR_W), .ADDR_W(ADDR_W)) bus ();

  weight_pingpong_buffer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .WR_W(WR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk_cal(clk_cal),
    .rst_cal(rst_cal),
    .bus    (bus)
  );

  always #5 clk_cal = ~clk_cal;
  always @(posedge clk_cal) begin
    cyc   <= cyc + 1;
    rst_q <= rst_cal;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pat(input int c, input int a);
    return 8'((c << 5) ^ (a & 255) ^ ((a >> 8) * 13));
  endfunction

  task automatic set_rd(input int c, input int addr);
    bus.rd_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(addr);
  endtask

  // Apply the spec rules for the edge that samples the current inputs, then advance one cycle.
  task automatic tick();
    exp_t e;
    bit   com, rel;
    int   a;
    if (rst_cal) begin
      m_wp = 0; m_rp = 0; m_cnt = 0; m_wr_rdy = 1'b1; m_bank_vld = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        exp_t keep[$];
        foreach (q[c][i]) if (q[c][i].due <= cyc) keep.push_back(q[c][i]);
        q[c] = keep;
      end
    end else begin
      if (bus.wr_vld && m_wr_rdy && int'(bus.wr_ch) < NUM_CH) begin
        for (int l = 0; l < LANES; l++) begin
          a = int'(bus.wr_waddr) * LANES + l;
          m_mem[m_wp][bus.wr_ch][a]   = bus.wr_data[l*DATA_W +: DATA_W];
          m_known[m_wp][bus.wr_ch][a] = 1'b1;
        end
      end
      if (m_bank_vld) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.stagger_mode) begin
            if (bus.rd_en[0]) begin
              a = int'(bus.rd_addr[ADDR_W-1:0]);
              e.due = cyc + 1 + c; e.data = m_mem[m_rp][c][a]; e.known = m_known[m_rp][c][a];
              q[c].push_back(e);
            end
          end else if (bus.rd_en[c]) begin
            a = int'(bus.rd_addr[c*ADDR_W +: ADDR_W]);
            e.due = cyc + 1; e.data = m_mem[m_rp][c][a]; e.known = m_known[m_rp][c][a];
            q[c].push_back(e);
          end
        end
      end
      com = bus.wr_commit && m_cnt < 2;
      rel = bus.rd_release && m_cnt > 0;
      if (com) begin m_wp = 1 - m_wp; m_cnt++; end
      if (rel) begin m_rp = 1 - m_rp; m_cnt--; end
      m_wr_rdy   = (m_cnt < 2);
      m_bank_vld = (m_cnt > 0);
    end
    @(posedge clk_cal);
    #1;
    chk("wr_rdy", 64'(bus.wr_rdy), 64'(m_wr_rdy));
    chk("bank_vld", 64'(bus.bank_vld), 64'(m_bank_vld));
    bus.wr_vld     = 1'b0;
    bus.wr_commit  = 1'b0;
    bus.rd_release = 1'b0;
    bus.rd_en      = '0;
  endtask

  task automatic write_word(input int c, input int w, input logic [63:0] d);
    bus.wr_vld   = 1'b1;
    bus.wr_ch    = 3'(c);
    bus.wr_waddr = 8'(w);
    bus.wr_data  = d;
    tick();
  endtask

  // Monitor: pop the expected result whenever a channel presents rd_vld.
  always @(negedge clk_cal) begin
    if (mon_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        exp_t       e;
        logic [7:0] d;
        d = bus.rd_data[c*DATA_W +: DATA_W];
        if (rst_q) begin
          last[c] = 8'h00;
          last_known[c] = 1'b1;
        end
        if (bus.rd_vld[c]) begin
          if (q[c].size() == 0) begin
            chk($sformatf("unexpected rd_vld ch%0d", c), 64'd1, 64'd0);
          end else begin
            e = q[c].pop_front();
            chk($sformatf("rd_vld timing ch%0d", c), 64'(cyc), 64'(e.due));
            if (e.known) chk($sformatf("rd_data ch%0d", c), 64'(d), 64'(e.data));
            last[c] = e.data;
            last_known[c] = e.known;
          end
        end else begin
          if (q[c].size() > 0 && q[c][0].due <= cyc) begin
            e = q[c].pop_front();
            chk($sformatf("missing rd_vld ch%0d", c), 64'd0, 64'd1);
            last[c] = e.data;
            last_known[c] = 1'b0;
          end
          if (last_known[c]) chk($sformatf("rd_data hold ch%0d", c), 64'(d), 64'(last[c]));
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    bus.wr_vld = 1'b0; bus.wr_ch = '0; bus.wr_waddr = '0; bus.wr_data = '0;
    bus.wr_commit = 1'b0; bus.rd_release = 1'b0; bus.stagger_mode = 1'b0;
    bus.rd_en = '0; bus.rd_addr = '0;
    m_wp = 0; m_rp = 0; m_cnt = 0; m_wr_rdy = 1'b1; m_bank_vld = 1'b0;
    rst_cal = 1'b1;
    tick();
    tick();
    rst_cal = 1'b0;
    mon_en = 1'b1;
    chk("reset wr_rdy", 64'(bus.wr_rdy), 64'd1);
    chk("reset bank_vld", 64'(bus.bank_vld), 64'd0);
    chk("reset rd_vld", 64'(bus.rd_vld), 64'd0);
    chk("reset rd_data", 64'(bus.rd_data), 64'd0);

    // fill bank 0 with the {ch,addr} pattern and hand it over
    for (int w = 0; w < DEPTH / LANES; w++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int l = 0; l < LANES; l++) d[l*8 +: 8] = pat(c, w * LANES + l);
        write_word(c, w, d);
      end
    end
    bus.wr_commit = 1'b1;
    tick();
    chk("commit bank_vld", 64'(bus.bank_vld), 64'd1);
    chk("commit wr_rdy", 64'(bus.wr_rdy), 64'd1);

    // independent reads on all channels, then random reads while bank 1 fills
    for (int c = 0; c < NUM_CH; c++) set_rd(c, c * 9);
    bus.rd_en = 8'hFF;
    tick();
    repeat (300) begin
      bus.rd_en = 8'($urandom);
      for (int c = 0; c < NUM_CH; c++) set_rd(c, int'($urandom_range(0, DEPTH - 1)));
      if ($urandom_range(0, 1) == 1) begin
        bus.wr_vld = 1'b1; bus.wr_ch = 3'($urandom); bus.wr_waddr = 8'($urandom);
        bus.wr_data = {$urandom, $urandom};
      end
      tick();
    end
    write_word(3, 4, 64'h0123_4567_89AB_CDEF);

    // systolic reads, then one read at address 5 with a release three cycles in
    bus.stagger_mode = 1'b1;
    tick();
    repeat (30) begin
      bus.rd_en = 8'($urandom);
      set_rd(0, int'($urandom_range(0, DEPTH - 1)));
      tick();
    end
    repeat (8) tick();
    bus.rd_en = 8'h01;
    set_rd(0, 5);
    tick();
    tick();
    tick();
    bus.rd_release = 1'b1;
    tick();
    chk("release bank_vld", 64'(bus.bank_vld), 64'd0);
    repeat (10) tick();
    bus.stagger_mode = 1'b0;
    tick();

    // two banks committed: writes refused, read shows the untouched word
    bus.wr_commit = 1'b1;
    tick();
    write_word(2, 10, {$urandom, $urandom});
    bus.wr_commit = 1'b1;
    tick();
    chk("full wr_rdy", 64'(bus.wr_rdy), 64'd0);
    write_word(3, 4, 64'hDEAD_BEEF_DEAD_BEEF);
    for (int l = 0; l < LANES; l++) begin
      bus.rd_en = 8'h08;
      set_rd(3, 32 + l);
      tick();
    end
    bus.rd_release = 1'b1;
    tick();
    chk("release wr_rdy", 64'(bus.wr_rdy), 64'd1);
    for (int l = 0; l < LANES; l++) begin
      bus.rd_en = 8'h04;
      set_rd(2, 80 + l);
      tick();
    end

    // simultaneous commit/release at count 1, 0 and 2
    bus.wr_commit = 1'b1; bus.rd_release = 1'b1;
    tick();
    chk("swap bank_vld", 64'(bus.bank_vld), 64'd1);
    chk("swap wr_rdy", 64'(bus.wr_rdy), 64'd1);
    bus.rd_en = 8'h08; set_rd(3, 32);
    tick();
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b1;
    tick();
    chk("empty release bank_vld", 64'(bus.bank_vld), 64'd0);
    bus.rd_en = 8'hFF;
    tick();
    bus.wr_commit = 1'b1; bus.rd_release = 1'b1;
    tick();
    chk("empty swap bank_vld", 64'(bus.bank_vld), 64'd1);
    bus.rd_en = 8'h08; set_rd(3, 33);
    tick();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b1; bus.rd_release = 1'b1;
    tick();
    chk("full swap wr_rdy", 64'(bus.wr_rdy), 64'd1);

    // random traffic including bank hand-offs
    repeat (400) begin
      bus.rd_en = 8'($urandom);
      for (int c = 0; c < NUM_CH; c++) set_rd(c, int'($urandom_range(0, DEPTH - 1)));
      if ($urandom_range(0, 1) == 1) begin
        bus.wr_vld = 1'b1; bus.wr_ch = 3'($urandom); bus.wr_waddr = 8'($urandom);
        bus.wr_data = {$urandom, $urandom};
      end
      bus.wr_commit  = ($urandom_range(0, 15) == 0);
      bus.rd_release = ($urandom_range(0, 15) == 0);
      tick();
    end

    // reset in the middle of a fill and a systolic read
    if (!m_bank_vld) begin
      bus.wr_commit = 1'b1;
      tick();
    end
    bus.stagger_mode = 1'b1;
    tick();
    bus.rd_en = 8'h01; set_rd(0, int'($urandom_range(0, DEPTH - 1)));
    bus.wr_vld = 1'b1; bus.wr_ch = 3'd1; bus.wr_waddr = 8'd7; bus.wr_data = {$urandom, $urandom};
    tick();
    bus.wr_vld = 1'b1; bus.wr_ch = 3'd2; bus.wr_waddr = 8'd8; bus.wr_data = {$urandom, $urandom};
    tick();
    rst_cal = 1'b1;
    bus.wr_vld = 1'b1; bus.wr_ch = 3'd5; bus.wr_waddr = 8'd9; bus.wr_data = {$urandom, $urandom};
    tick();
    rst_cal = 1'b0;
    chk("mid reset rd_vld", 64'(bus.rd_vld), 64'd0);
    chk("mid reset rd_data", 64'(bus.rd_data), 64'd0);
    chk("mid reset wr_rdy", 64'(bus.wr_rdy), 64'd1);
    chk("mid reset bank_vld", 64'(bus.bank_vld), 64'd0);
    repeat (4) begin
      bus.rd_en = 8'h01;
      tick();
    end
    repeat (8) tick();
    bus.stagger_mode = 1'b0;
    tick();
    repeat (3) begin
      bus.rd_en = 8'hFF;
      tick();
    end
    chk("refused bank_vld", 64'(bus.bank_vld), 64'd0);
    bus.wr_commit = 1'b1;
    tick();
    chk("recommit bank_vld", 64'(bus.bank_vld), 64'd1);
    repeat (20) begin
      bus.rd_en = 8'hFF;
      for (int c = 0; c < NUM_CH; c++) set_rd(c, int'($urandom_range(0, DEPTH - 1)));
      tick();
    end
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
